// File: rtl/adc_scan_scheduler.sv
// rtl/adc_scan_scheduler.sv - round-robin ADC scan scheduler with UART config; ADC_SCAN_OVF_CNT_EN adds ovf_cnt
module adc_scan_scheduler #(
   parameter int WIDTH  = 8,
   parameter int NUM_CH = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              activate,
   output logic              done,
   input  logic [7:0]        rx_data,
   input  logic              rx_ready,
   input  logic              run,
   output logic [NUM_CH-1:0] adc_sel,
   output logic              adc_clk,
   input  logic [WIDTH-1:0]  adc_data,
   output logic [WIDTH-1:0]  sample_data,
   output logic [2:0]        sample_ch,
   output logic              sample_valid,
   input  logic              sample_ready,
`ifdef ADC_SCAN_OVF_CNT_EN
   output logic              ovf,
   output logic [7:0]        ovf_cnt
`else
   output logic              ovf
`endif
);

   typedef enum logic [1:0] {CFG_IDLE, CFG_MASK, CFG_DIV, CFG_DONE} cfg_state_t;

   cfg_state_t        cfg_state;
   logic [NUM_CH-1:0] stage_mask;   // mask byte held until the div byte commits both
   logic [NUM_CH-1:0] mask_r;
   logic [7:0]        div_r;
   logic [7:0]        div_cnt;
   logic [2:0]        cur_ch;       // channel currently driven on adc_sel
   logic [2:0]        seq_ch;       // channel strobed by the sequence in flight
   logic              capt_stage;   // high during T+2

   logic [NUM_CH-1:0] rx_mask;
   logic [7:0]        rx_div;
   logic              commit;
   logic              tick;
   logic              capture;
   logic              drop;
   logic [2:0]        sel_base;
   logic [2:0]        sel_next;

   // next enabled channel above ch, wrapping; stays on ch when it is the only one
   function automatic logic [2:0] next_enabled(input logic [2:0] ch, input logic [NUM_CH-1:0] m);
      logic [2:0] r;
      logic       found;
      int         c;
      r     = ch;
      found = 1'b0;
      for (int i = 1; i <= NUM_CH; i++) begin
         c = int'(ch) + i;
         if (c >= NUM_CH) c = c - NUM_CH;
         if (!found && m[c]) begin
            r     = 3'(c);
            found = 1'b1;
         end
      end
      return r;
   endfunction

   function automatic logic [2:0] lowest_enabled(input logic [NUM_CH-1:0] m);
      logic [2:0] r;
      r = 3'd0;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (m[i]) r = 3'(i);
      end
      return r;
   endfunction

   assign rx_mask  = (rx_data[NUM_CH-1:0] == '0) ? NUM_CH'(1) : rx_data[NUM_CH-1:0];
   assign rx_div   = (rx_data < 8'd3) ? 8'd3 : rx_data;
   assign commit   = (cfg_state == CFG_DIV) && rx_ready;
   assign tick     = run && (div_cnt == div_r - 8'd1);
   assign capture  = capt_stage && run;
   assign drop     = capture && sample_valid && !sample_ready;
   // the in-flight sequence advances with the mask it started under; a commit then
   // relocates the selection if that channel is no longer enabled
   assign sel_base = capture ? next_enabled(seq_ch, mask_r) : cur_ch;
   assign sel_next = (commit && !stage_mask[sel_base]) ? lowest_enabled(stage_mask) : sel_base;
   assign adc_sel  = NUM_CH'(1) << cur_ch;

   // configuration command FSM: mask byte, div byte, then done until activate drops
   always_ff @(posedge clk) begin
      if (rst) begin
         cfg_state  <= CFG_IDLE;
         done       <= 1'b0;
         stage_mask <= NUM_CH'(1);
         mask_r     <= NUM_CH'(1);
         div_r      <= 8'd3;
      end else begin
         case (cfg_state)
            CFG_IDLE: begin
               if (activate) cfg_state <= CFG_MASK;
            end
            CFG_MASK: begin
               if (rx_ready) begin
                  stage_mask <= rx_mask;
                  cfg_state  <= CFG_DIV;
               end
            end
            CFG_DIV: begin
               if (rx_ready) begin
                  mask_r    <= stage_mask;
                  div_r     <= rx_div;
                  done      <= 1'b1;
                  cfg_state <= CFG_DONE;
               end
            end
            default: begin
               if (!activate) begin
                  done      <= 1'b0;
                  cfg_state <= CFG_IDLE;
               end
            end
         endcase
      end
   end

   // divider and T / T+1 / T+2 scan pipeline
   always_ff @(posedge clk) begin
      if (rst) begin
         div_cnt    <= 8'd0;
         adc_clk    <= 1'b0;
         capt_stage <= 1'b0;
         cur_ch     <= 3'd0;
         seq_ch     <= 3'd0;
      end else begin
         if (commit || !run || tick) div_cnt <= 8'd0;
         else                        div_cnt <= div_cnt + 8'd1;
         adc_clk    <= tick;
         capt_stage <= adc_clk && run;
         if (tick) seq_ch <= cur_ch;
         cur_ch <= sel_next;
      end
   end

   // single-entry sample holding register with valid/ready handshake
   always_ff @(posedge clk) begin
      if (rst) begin
         sample_data  <= '0;
         sample_ch    <= 3'd0;
         sample_valid <= 1'b0;
      end else if (capture && !drop) begin
         sample_data  <= adc_data;
         sample_ch    <= seq_ch;
         sample_valid <= 1'b1;
      end else if (sample_valid && sample_ready) begin
         sample_valid <= 1'b0;
      end
   end

`ifdef ADC_SCAN_OVF_CNT_EN
   // saturating dropped-sample counter; a config commit starts a fresh count
   always_ff @(posedge clk) begin
      if (rst || commit)                 ovf_cnt <= 8'd0;
      else if (drop && ovf_cnt != 8'hFF) ovf_cnt <= ovf_cnt + 8'd1;
   end

   assign ovf = (ovf_cnt != 8'd0);
`else
   // sticky overflow flag; a config commit clears it
   always_ff @(posedge clk) begin
      if (rst || commit) ovf <= 1'b0;
      else if (drop)     ovf <= 1'b1;
   end
`endif

endmodule
